// File: rtl/piso_shifter.sv
// Parallel-in, serial-out shifter.
// Accepts a BIT_WIDTH word on a load handshake while idle and shifts it out
// one bit every TICK_DIV clocks on sout. sout_valid frames the data bits, and
// done pulses for one cycle after the last bit. led mirrors the shift register
// for on-board debug. Every output is decoded from registered state only, so
// din and load never reach an output combinationally.
module piso_shifter #(
  parameter int unsigned BIT_WIDTH = 8,    // word width, 2 or more
  parameter bit          MSB_FIRST = 1'b1, // 1: bit BIT_WIDTH-1 goes first
  parameter int unsigned TICK_DIV  = 1     // clocks per serial bit, 1 or more
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [BIT_WIDTH-1:0] din,
  input  logic                 load,
  output logic                 ready,
  output logic                 sout,
  output logic                 sout_valid,
  output logic                 done,
  output logic [BIT_WIDTH-1:0] led
);

  // Counter widths. The divider counter keeps at least one bit so that the
  // TICK_DIV == 1 case still has a legal vector; it then stays at zero.
  localparam int unsigned CNT_W = $clog2(BIT_WIDTH);
  localparam int unsigned DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(BIT_WIDTH - 1);
  localparam logic [DIV_W-1:0] LAST_TICK = DIV_W'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  state_e                 state_q,   state_d;
  logic [BIT_WIDTH-1:0]   shreg_q,   shreg_d;
  logic [CNT_W-1:0]       bit_cnt_q, bit_cnt_d;
  logic [DIV_W-1:0]       div_cnt_q, div_cnt_d;

  logic                   last_tick;
  logic                   last_bit;
  logic                   head;
  logic [BIT_WIDTH-1:0]   shifted;

  // End-of-hold and end-of-frame flags. The counters stop at their terminal
  // values, so an equality compare is enough and they can never wrap.
  assign last_tick = (div_cnt_q == LAST_TICK);
  assign last_bit  = (bit_cnt_q == LAST_BIT);

  // Head bit and the register shifted one place toward the head, zero-filled.
  assign head    = MSB_FIRST ? shreg_q[BIT_WIDTH-1] : shreg_q[0];
  assign shifted = MSB_FIRST ? {shreg_q[BIT_WIDTH-2:0], 1'b0}
                             : {1'b0, shreg_q[BIT_WIDTH-1:1]};

  // State register.
  // NOTE: sequential blocks use non-blocking (<=) so every register samples
  // the pre-edge value of every other register, independent of block order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: IDLE -> SHIFT on load, SHIFT -> DONE after the hold of
  // the last bit, DONE -> IDLE unconditionally.
  // NOTE: every variable gets a default at the top of a comb block; a path
  // that leaves one unassigned would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (load) state_d = SHIFT;
      SHIFT:   if (last_tick && last_bit) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath next-state: capture din on acceptance, then count out each hold
  // and shift toward the head between bits. The last bit is not shifted, so
  // led keeps showing it until the next load.
  always_comb begin
    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;
    div_cnt_d = div_cnt_q;
    unique case (state_q)
      IDLE: begin
        if (load) begin
          shreg_d   = din;
          bit_cnt_d = '0;
          div_cnt_d = '0;
        end
      end
      SHIFT: begin
        if (!last_tick) begin
          div_cnt_d = div_cnt_q + DIV_W'(1);
        end else if (!last_bit) begin
          shreg_d   = shifted;
          bit_cnt_d = bit_cnt_q + CNT_W'(1);
          div_cnt_d = '0;
        end
      end
      default: ;
    endcase
  end

  // Datapath registers.
  // NOTE: the shift register is a flat vector, not a memory array, so it is
  // reset along with the counters; led must read zero straight out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg_q   <= '0;
      bit_cnt_q <= '0;
      div_cnt_q <= '0;
    end else begin
      shreg_q   <= shreg_d;
      bit_cnt_q <= bit_cnt_d;
      div_cnt_q <= div_cnt_d;
    end
  end

  // Output decode from state and registers only.
  always_comb begin
    ready      = 1'b0;
    sout_valid = 1'b0;
    sout       = 1'b0;
    done       = 1'b0;
    unique case (state_q)
      IDLE:  ready = 1'b1;
      SHIFT: begin
        sout_valid = 1'b1;
        sout       = head;
      end
      DONE:  done = 1'b1;
      default: ;
    endcase
  end

  assign led = shreg_q;

endmodule

// File: tb/tb_piso_shifter.sv
// Directed bench for piso_shifter. Three instances cover MSB-first at one bit
// per clock, LSB-first at one bit per clock, and MSB-first with TICK_DIV = 4.
// Inputs are driven and outputs sampled on the falling edge, so the sample
// taken after rising edge En is cycle n.
module tb_piso_shifter;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  // MSB-first, TICK_DIV = 1
  logic [7:0] din_m;
  logic       load_m, ready_m, sout_m, valid_m, done_m;
  logic [7:0] led_m;
  // LSB-first, TICK_DIV = 1
  logic [7:0] din_l;
  logic       load_l, ready_l, sout_l, valid_l, done_l;
  logic [7:0] led_l;
  // MSB-first, TICK_DIV = 4
  logic [7:0] din_d;
  logic       load_d, ready_d, sout_d, valid_d, done_d;
  logic [7:0] led_d;

  piso_shifter #(.BIT_WIDTH(8), .MSB_FIRST(1'b1), .TICK_DIV(1)) u_msb (
    .clk(clk), .rst_n(rst_n), .din(din_m), .load(load_m), .ready(ready_m),
    .sout(sout_m), .sout_valid(valid_m), .done(done_m), .led(led_m)
  );

  piso_shifter #(.BIT_WIDTH(8), .MSB_FIRST(1'b0), .TICK_DIV(1)) u_lsb (
    .clk(clk), .rst_n(rst_n), .din(din_l), .load(load_l), .ready(ready_l),
    .sout(sout_l), .sout_valid(valid_l), .done(done_l), .led(led_l)
  );

  piso_shifter #(.BIT_WIDTH(8), .MSB_FIRST(1'b1), .TICK_DIV(4)) u_div (
    .clk(clk), .rst_n(rst_n), .din(din_d), .load(load_d), .ready(ready_d),
    .sout(sout_d), .sout_valid(valid_d), .done(done_d), .led(led_d)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance to the sample point of the next cycle.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // One MSB-first frame on u_msb. With disturb set, din is cleared in cycle 2
  // and load is pulsed in cycle 3; neither may affect the frame in flight.
  task automatic msb_frame(input logic [7:0] word, input logic [7:0] bits,
                           input bit disturb);
    din_m  = word;
    load_m = 1'b1;
    tick();
    load_m = 1'b0;
    check("msb led at cycle 1", led_m, word);
    for (int k = 1; k <= 8; k++) begin
      check($sformatf("msb sout c%0d", k), sout_m, bits[8-k]);
      check($sformatf("msb valid c%0d", k), valid_m, 1);
      check($sformatf("msb ready c%0d", k), ready_m, 0);
      check($sformatf("msb done c%0d", k), done_m, 0);
      if (disturb && k == 2) din_m = 8'h00;
      if (disturb && k == 3) load_m = 1'b1;
      if (disturb && k == 4) load_m = 1'b0;
      tick();
    end
    check("msb done c9", done_m, 1);
    check("msb valid c9", valid_m, 0);
    check("msb sout c9", sout_m, 0);
    check("msb ready c9", ready_m, 0);
    tick();
    check("msb ready c10", ready_m, 1);
    check("msb done c10", done_m, 0);
    for (int k = 11; k <= 13; k++) begin
      tick();
      check($sformatf("msb no frame c%0d", k), valid_m, 0);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n  = 1'b0;
    din_m  = '0; load_m = 1'b0;
    din_l  = '0; load_l = 1'b0;
    din_d  = '0; load_d = 1'b0;

    // Reset state
    #2;
    check("rst ready m", ready_m, 1);
    check("rst valid m", valid_m, 0);
    check("rst led l", led_l, 8'h00);
    check("rst ready d", ready_d, 1);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Reset asserted mid-SHIFT with FF loaded: outputs return at once
    din_m  = 8'hFF;
    load_m = 1'b1;
    tick();
    load_m = 1'b0;
    tick();
    tick();
    check("pre-rst valid", valid_m, 1);
    check("pre-rst led", led_m, 8'hFC);
    #2 rst_n = 1'b0;
    #1;
    check("rst sout", sout_m, 0);
    check("rst valid", valid_m, 0);
    check("rst ready", ready_m, 1);
    check("rst done", done_m, 0);
    check("rst led", led_m, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // MSB-first A5, clean, then with din change and a stray load
    msb_frame(8'hA5, 8'b1010_0101, 1'b0);
    msb_frame(8'hA5, 8'b1010_0101, 1'b1);

    // LSB-first 01
    din_l  = 8'h01;
    load_l = 1'b1;
    tick();
    load_l = 1'b0;
    check("lsb led c1", led_l, 8'h01);
    check("lsb sout c1", sout_l, 1);
    tick();
    check("lsb led c2", led_l, 8'h00);
    for (int k = 2; k <= 8; k++) begin
      check($sformatf("lsb sout c%0d", k), sout_l, 0);
      check($sformatf("lsb valid c%0d", k), valid_l, 1);
      tick();
    end
    check("lsb done c9", done_l, 1);
    tick();
    check("lsb ready c10", ready_l, 1);

    // TICK_DIV = 4, C3: 8 high, 16 low, 8 high
    din_d  = 8'hC3;
    load_d = 1'b1;
    tick();
    load_d = 1'b0;
    for (int k = 1; k <= 32; k++) begin
      check($sformatf("div sout c%0d", k), sout_d, (k <= 8 || k >= 25) ? 1 : 0);
      check($sformatf("div valid c%0d", k), valid_d, 1);
      check($sformatf("div done c%0d", k), done_d, 0);
      tick();
    end
    check("div done c33", done_d, 1);
    check("div valid c33", valid_d, 0);
    tick();
    check("div ready c34", ready_d, 1);
    check("div done c34", done_d, 0);

    // load held high with 5A: 8 valid, 2 gap, repeating
    din_m  = 8'h5A;
    load_m = 1'b1;
    tick();
    for (int k = 1; k <= 30; k++) begin
      automatic int  pos = (k - 1) % 10;
      automatic logic [7:0] w = 8'b0101_1010;
      check($sformatf("b2b valid c%0d", k), valid_m, (pos < 8) ? 1 : 0);
      check($sformatf("b2b done c%0d", k), done_m, (pos == 8) ? 1 : 0);
      if (pos < 8) check($sformatf("b2b sout c%0d", k), sout_m, w[7-pos]);
      if (k == 29) load_m = 1'b0;
      tick();
    end
    check("b2b stopped", valid_m, 0);
    check("b2b ready", ready_m, 1);

    // Abort F0 after 3 bits, then send 0F in full
    din_m  = 8'hF0;
    load_m = 1'b1;
    tick();
    load_m = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      check($sformatf("abort sout c%0d", k), sout_m, 1);
      if (k < 3) tick();
    end
    #2 rst_n = 1'b0;
    #2 rst_n = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 10; k++) begin
      check($sformatf("abort no done %0d", k), done_m, 0);
      check($sformatf("abort idle %0d", k), ready_m, 1);
      tick();
    end
    din_m  = 8'h0F;
    load_m = 1'b1;
    tick();
    load_m = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      check($sformatf("post sout c%0d", k), sout_m, (k >= 5) ? 1 : 0);
      check($sformatf("post valid c%0d", k), valid_m, 1);
      tick();
    end
    check("post done c9", done_m, 1);
    tick();
    check("post ready c10", ready_m, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
